// File: rtl/pe_pkg.sv
// Shared types and helpers for the convolution PE front end and datapath.
package pe_pkg;

  typedef enum logic [0:0] {
    S_LOAD    = 1'b0,
    S_PRESENT = 1'b1
  } feeder_state_e;

  // Bit offset of window element (i,j,c); i is the row from the top, j the column from the left.
  function automatic int unsigned win_offset(input int unsigned i, input int unsigned j,
                                             input int unsigned c, input int unsigned k,
                                             input int unsigned n_ch, input int unsigned dw);
    return ((i * k + j) * n_ch + c) * dw;
  endfunction

endpackage

// File: rtl/pe_line_buffer.sv
// One image-row delay line, read and written at the same column index.
module pe_line_buffer #(
  parameter int unsigned pDEPTH = 28,
  parameter int unsigned pWIDTH = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [$clog2(pDEPTH)-1:0] addr,
  input  logic [pWIDTH-1:0]         din,
  output logic [pWIDTH-1:0]         dout
);

  // Storage is deliberately unreset; every entry is rewritten before it can reach a window.
  logic [pWIDTH-1:0] mem [pDEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/pe_conv_window_feeder.sv
// Builds KxK sliding windows from a raster pixel stream and hands each one to the MAC controller.
module pe_conv_window_feeder
  import pe_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH  = 8,
  parameter int unsigned pIN_CHANNEL  = 1,
  parameter int unsigned pKERNEL_SIZE = 3,
  parameter int unsigned pIMG_WIDTH   = 28,
  parameter int unsigned pIMG_HEIGHT  = 28,
  localparam int unsigned K        = pKERNEL_SIZE,
  localparam int unsigned PixW     = pIN_CHANNEL * pDATA_WIDTH,
  localparam int unsigned WinW     = K * K * PixW,
  localparam int unsigned OutRowW  = (pIMG_HEIGHT - K + 1 > 1) ? $clog2(pIMG_HEIGHT - K + 1) : 1,
  localparam int unsigned OutColW  = (pIMG_WIDTH - K + 1 > 1) ? $clog2(pIMG_WIDTH - K + 1) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PixW-1:0]    s_data,
  output logic               pe_en,
  input  logic               pe_ready,
  output logic [WinW-1:0]    window,
  output logic [OutRowW-1:0] out_row,
  output logic [OutColW-1:0] out_col,
  output logic               frame_done
);

  localparam int unsigned RowW = $clog2(pIMG_HEIGHT);
  localparam int unsigned ColW = $clog2(pIMG_WIDTH);

  localparam logic [RowW-1:0]    RowLast    = RowW'(pIMG_HEIGHT - 1);
  localparam logic [ColW-1:0]    ColLast    = ColW'(pIMG_WIDTH - 1);
  localparam logic [RowW-1:0]    RowFirstWin = RowW'(K - 1);
  localparam logic [ColW-1:0]    ColFirstWin = ColW'(K - 1);
  localparam logic [OutRowW-1:0] OutRowLast = OutRowW'(pIMG_HEIGHT - K);
  localparam logic [OutColW-1:0] OutColLast = OutColW'(pIMG_WIDTH - K);

  feeder_state_e state_q, state_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [ColW-1:0]    col_q, col_d;
  logic [WinW-1:0]    window_q, window_d;
  logic [OutRowW-1:0] out_row_q, out_row_d;
  logic [OutColW-1:0] out_col_q, out_col_d;
  logic               frame_done_q, frame_done_d;

  logic pix_xfer, win_xfer, win_complete, last_window;

  logic [PixW-1:0] lb_dout [K-1];
  logic [PixW-1:0] col_in  [K];

  assign s_ready    = (state_q == S_LOAD);
  assign pe_en      = (state_q == S_PRESENT);
  assign window     = window_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

  assign pix_xfer     = s_valid && s_ready;
  assign win_xfer     = pe_en && pe_ready;
  assign win_complete = (row_q >= RowFirstWin) && (col_q >= ColFirstWin);
  assign last_window  = (out_row_q == OutRowLast) && (out_col_q == OutColLast);

  // lb[0] holds the previous row, lb[K-2] the oldest; each stage feeds the next.
  for (genvar r = 0; r < K - 1; r++) begin : g_lb
    logic [PixW-1:0] lb_din;
    if (r == 0) begin : g_head
      assign lb_din = s_data;
    end else begin : g_chain
      assign lb_din = lb_dout[r-1];
    end
    pe_line_buffer #(
      .pDEPTH(pIMG_WIDTH),
      .pWIDTH(PixW)
    ) u_lb (
      .clk (clk),
      .we  (pix_xfer),
      .addr(col_q),
      .din (lb_din),
      .dout(lb_dout[r])
    );
  end

  // Incoming window column, top row first: oldest line buffer down to the live pixel.
  for (genvar i = 0; i < K; i++) begin : g_col_in
    if (i == K - 1) begin : g_live
      assign col_in[i] = s_data;
    end else begin : g_buf
      assign col_in[i] = lb_dout[K-2-i];
    end
  end

  always_comb begin
    window_d = window_q;
    if (pix_xfer) begin
      for (int unsigned i = 0; i < K; i++) begin
        for (int unsigned j = 0; j < K - 1; j++) begin
          window_d[win_offset(i, j, 0, K, pIN_CHANNEL, pDATA_WIDTH) +: PixW] =
            window_q[win_offset(i, j + 1, 0, K, pIN_CHANNEL, pDATA_WIDTH) +: PixW];
        end
        window_d[win_offset(i, K - 1, 0, K, pIN_CHANNEL, pDATA_WIDTH) +: PixW] = col_in[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    frame_done_d = 1'b0;

    if (pix_xfer) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    unique case (state_q)
      S_LOAD: begin
        if (pix_xfer && win_complete) begin
          state_d   = S_PRESENT;
          out_row_d = OutRowW'(row_q - RowFirstWin);
          out_col_d = OutColW'(col_q - ColFirstWin);
        end
      end
      S_PRESENT: begin
        if (win_xfer) begin
          state_d      = S_LOAD;
          frame_done_d = last_window;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      row_q        <= '0;
      col_q        <= '0;
      window_q     <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      window_q     <= window_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_pe_conv_window_feeder.sv
// Directed bench for the window feeder with K=3 on a 4x4 single-channel frame.
module tb_pe_conv_window_feeder;

  localparam int DW = 8;
  localparam int K  = 3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NWIN = (W - K + 1) * (H - K + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [DW-1:0]  s_data = '0;
  logic           pe_en;
  logic           pe_ready = 1'b0;
  logic [K*K*DW-1:0] window;
  logic [0:0]     out_row;
  logic [0:0]     out_col;
  logic           frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int r;
    int c;
    int tl;
  } vec_t;
  vec_t vecs[NWIN];

  pe_conv_window_feeder #(
    .pDATA_WIDTH (DW),
    .pIN_CHANNEL (1),
    .pKERNEL_SIZE(K),
    .pIMG_WIDTH  (W),
    .pIMG_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .pe_en     (pe_en),
    .pe_ready  (pe_ready),
    .window    (window),
    .out_row   (out_row),
    .out_col   (out_col),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [K*K*DW-1:0] act,
                     input logic [K*K*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Window whose top-left input pixel has raster index tl, pixel value = base + index.
  function automatic logic [K*K*DW-1:0] exp_win(input int base, input int tl);
    logic [K*K*DW-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*DW +: DW] = DW'(base + tl + i * W + j);
    return w;
  endfunction

  // Streams one frame; stall holds pe_ready low for that many cycles on the first window,
  // stop ends the stream once that many pixels have been consumed.
  task automatic run_frame(input string tag, input int base, input bit gap, input int stall,
                           input int stop);
    int idx = 0;
    int widx = 0;
    int fd = 0;
    int stall_left = stall;
    bit tog = 1'b0;
    bit seen_en = 1'b0;
    bit resumed = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (stop < W * H && idx >= stop) begin
        chk({tag, "_no_early_window"}, pe_en, 0);
        s_valid = 1'b0;
        return;
      end
      if (frame_done) begin
        fd++;
        chk({tag, "_done_after_last"}, widx, NWIN);
        s_valid  = 1'b0;
        pe_ready = 1'b0;
        break;
      end
      if (stall > 0 && widx == 1 && !resumed) begin
        resumed = 1'b1;
        chk({tag, "_resume_s_ready"}, s_ready, 1);
        chk({tag, "_resume_pe_en"}, pe_en, 0);
      end
      if (pe_en) begin
        if (!seen_en) begin
          seen_en = 1'b1;
          chk({tag, "_first_en_latency"}, idx, 11);
        end
        chk({tag, "_window_count"}, (widx < NWIN), 1);
        if (widx < NWIN) begin
          chk({tag, "_window"}, window, exp_win(base, vecs[widx].tl));
          chk({tag, "_out_row"}, out_row, vecs[widx].r);
          chk({tag, "_out_col"}, out_col, vecs[widx].c);
        end
        if (widx == 0 && stall_left > 0) begin
          chk({tag, "_stall_s_ready"}, s_ready, 0);
          stall_left--;
          pe_ready = 1'b0;
        end else begin
          pe_ready = 1'b1;
          widx++;
        end
      end else begin
        pe_ready = 1'b0;
      end
      if (s_ready) begin
        if (idx < W * H) begin
          tog     = ~tog;
          s_valid = gap ? tog : 1'b1;
          s_data  = DW'(base + idx);
          if (s_valid) idx++;
        end else begin
          s_valid = 1'b0;
        end
      end else begin
        // Junk offered while not ready; it would corrupt a later window if accepted.
        s_valid = 1'b1;
        s_data  = 8'hEE;
      end
    end
    if (stop >= W * H) begin
      chk({tag, "_windows_total"}, widx, NWIN);
      chk({tag, "_frame_done_pulses"}, fd, 1);
      @(negedge clk);
      chk({tag, "_frame_done_single"}, frame_done, 0);
    end
  endtask

  initial begin
    vecs[0] = '{r: 0, c: 0, tl: 0};
    vecs[1] = '{r: 0, c: 1, tl: 1};
    vecs[2] = '{r: 1, c: 0, tl: 4};
    vecs[3] = '{r: 1, c: 1, tl: 5};

    repeat (3) @(negedge clk);
    chk("reset_s_ready", s_ready, 1);
    chk("reset_pe_en", pe_en, 0);
    chk("reset_window", window, 0);
    chk("reset_out_row", out_row, 0);
    chk("reset_out_col", out_col, 0);
    chk("reset_frame_done", frame_done, 0);
    rst_n = 1'b1;

    run_frame("cont", 0, 1'b0, 0, W * H);
    run_frame("b2b", 100, 1'b0, 0, W * H);
    run_frame("gaps", 0, 1'b1, 0, W * H);
    run_frame("stall", 0, 1'b0, 5, W * H);

    run_frame("partial", 0, 1'b0, 0, 7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_s_ready", s_ready, 1);
    chk("midreset_pe_en", pe_en, 0);
    chk("midreset_window", window, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("restart", 0, 1'b0, 0, W * H);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_conv_window_feeder.md
# pe_conv_window_feeder

Front end of the convolution PE: accepts a raster-order pixel stream, keeps K-1 line buffers plus a K×K window register, and presents each complete K×K×pIN_CHANNEL window to the MAC controller/datapath. It drives the controller's `en` input (`pe_en`) and holds each window stable until the controller signals `pe_ready`. Stride 1, no padding, one frame of pIMG_HEIGHT×pIMG_WIDTH at a time.

## Interface
- pDATA_WIDTH, 8, bits per channel sample
- pIN_CHANNEL, 1, channels per pixel
- pKERNEL_SIZE, 3, window side K (K ≥ 2)
- pIMG_WIDTH, 28, pixels per row (≥ K)
- pIMG_HEIGHT, 28, rows per frame (≥ K)

- clk  in  1  clock; the block uses a single clock
- rst_n  in  1  reset, asynchronous assert, active-low
- s_valid  in  1  input pixel valid
- s_ready  out  1  feeder can accept a pixel
- s_data  in  pIN_CHANNEL*pDATA_WIDTH  pixel; channel c at [c*DW +: DW]
- pe_en  out  1  window valid; drives the controller's en
- pe_ready  in  1  controller accepts the current window
- window  out  K*K*pIN_CHANNEL*pDATA_WIDTH  element (i,j,c) at [((i*K+j)*pIN_CHANNEL+c)*DW +: DW]; i=0 is the top row, j=0 is the left column
- out_row  out  $clog2(pIMG_HEIGHT-K+1)  output-map row of the presented window
- out_col  out  $clog2(pIMG_WIDTH-K+1)  output-map column of the presented window
- frame_done  out  1  one-cycle pulse after the last window of a frame is accepted

## Operation
- FSM states:
  - S_LOAD: s_ready=1, pe_en=0.
  - S_PRESENT: s_ready=0, pe_en=1.
- Pixel transfer = s_valid && s_ready. Window transfer = pe_en && pe_ready.
- On each pixel transfer at counter position (row, col):
  - Right column of the new window, top to bottom: lb[K-2][col], …, lb[0][col], s_data.
  - Window shifts one column left; that column enters at j=K-1.
  - Line buffers update: lb[0][col] ← s_data, lb[r][col] ← lb[r-1][col].
  - col wraps at pIMG_WIDTH-1, then row increments.
- If the transferred pixel has row ≥ K-1 and col ≥ K-1:
  - Go to S_PRESENT.
  - Latch out_row = row-(K-1) and out_col = col-(K-1).
  - Otherwise stay in S_LOAD.
- In S_PRESENT, on window transfer:
  - Return to S_LOAD.
  - If that window was at (pIMG_HEIGHT-1, pIMG_WIDTH-1) input position: pulse frame_done, and row/col are already 0.
- window, out_row and out_col are constant for the whole S_PRESENT interval.
- Line-buffer storage is not reset. It is never read into a presented window before being written in the current frame.
- Windows with col < K-1 contain stale data from the previous row. They are never presented.

## Timing
- Reset values:
  - State S_LOAD, so s_ready=1.
  - pe_en=0, window=0, out_row=0, out_col=0, frame_done=0, row/col counters 0.
- Latency: a pixel transferred in cycle t that completes a window gives pe_en=1 in cycle t+1.
- Minimum cost is 2 cycles per window-producing pixel. Each present is at least 1 cycle, with no pixel intake during it.
- pe_en is registered and must not depend combinationally on pe_ready. The controller derives pe_ready from en, so this avoids a loop.
- s_valid low in S_LOAD: counters and window hold.
- s_valid while s_ready=0: ignored; the producer holds the data.
- frame_done is asserted in the cycle after the final window transfer. The next frame's first pixel may be accepted in that same cycle.
- Asynchronous reset mid-frame clears all state immediately. Any partial frame and any pending window are discarded.
- Counter wrap: col at pIMG_WIDTH-1 → 0 with row+1. Row at pIMG_HEIGHT-1 → 0.

## Structure
- Shared package (pe_pkg):
  - Feeder state enum {S_LOAD, S_PRESENT}.
  - Window bit-offset function for (i,j,c) given K, pIN_CHANNEL, DW; reused by the datapath for unpacking.
- One sub-module, pe_line_buffer:
  - One pIMG_WIDTH-deep, pIN_CHANNEL*DW-wide row delay, read and written at index col.
  - Instantiated K-1 times and chained.
- Top: FSM, row/col counters, K×K window shift register, position latches.

## Test plan
All scenarios use K=3, W=H=4, pIN_CHANNEL=1, DW=8, with pixel value = raster index 0..15 unless stated.
- Reset: hold rst_n=0 → s_ready=1, pe_en=0, window=0, out_row=out_col=0, frame_done=0.
- Full frame, pe_ready=1, s_valid=1 continuously:
  - First pe_en comes the cycle after pixel 10.
  - First window = {0,1,2,4,5,6,8,9,10}, position (0,0).
  - Next windows: position (0,1) {1,2,3,5,6,7,9,10,11}, then (1,0), then (1,1) {5,6,7,9,10,11,13,14,15}.
  - Exactly 4 windows; frame_done pulses once after the 4th.
- Backpressure: pe_ready=0 for 5 cycles during the first present → pe_en, window and position stable; s_ready=0; pixel 11 is not consumed until 1 cycle after pe_ready=1.
- Input gaps: s_valid toggled 1/0 every cycle → identical window sequence and values as the continuous case.
- Back-to-back frames: second frame with values 100+index → first window is {100,101,102,104,105,106,108,109,110} at (0,0), with no stale first-frame data.
- Reset mid-frame: assert rst_n=0 after pixel 6, then restart the frame → first window is again {0,1,2,4,5,6,8,9,10}, and no window is presented before pixel 10.
